// File: rtl/trap_halt_ctrl.sv
// Ebreak trap responder: accepts the commit-stage trap, stalls the core while
// writebacks drain, then holds a sticky halted/verdict status plus run counters.
module trap_halt_ctrl #(
  parameter int XLEN      = 64,
  parameter int DRAIN_MAX = 16,
  parameter int CNT_W     = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             trap_valid,
  input  logic [XLEN-1:0]  trap_code,
  input  logic [XLEN-1:0]  trap_pc,
  output logic             trap_ready,
  input  logic             inst_retire,
  input  logic             wb_pending,
  output logic             stall,
  output logic             halted,
  output logic             good_trap,
  output logic             bad_trap,
  output logic             drain_tmo,
  output logic [XLEN-1:0]  exit_code,
  output logic [XLEN-1:0]  exit_pc,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DW = (DRAIN_MAX > 2) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX - 1);

  state_t        state;
  logic [DW-1:0] drain_cnt;
  logic          drain_end;
  logic          code_zero;

  // The drain ends either because writebacks are gone or the budget ran out;
  // wb_pending still high at that point is what marks the timeout.
  assign drain_end = !wb_pending || (drain_cnt == DRAIN_LAST);
  assign code_zero = (exit_code == '0);

  // NOTE: every state element, counters and latches included, is cleared by the
  // synchronous reset, and all of it is assigned with non-blocking <= so the
  // next-state reads below always see the pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= RUN;
      trap_ready <= 1'b1;
      stall      <= 1'b0;
      halted     <= 1'b0;
      good_trap  <= 1'b0;
      bad_trap   <= 1'b0;
      drain_tmo  <= 1'b0;
      exit_code  <= '0;
      exit_pc    <= '0;
      drain_cnt  <= '0;
      cycle_cnt  <= '0;
      instret    <= '0;
    end else begin
      if (!halted) cycle_cnt <= cycle_cnt + CNT_W'(1);

      unique case (state)
        RUN: begin
          // A retire in the accept cycle is the ebreak itself and still counts.
          if (inst_retire) instret <= instret + CNT_W'(1);
          if (trap_valid && trap_ready) begin
            exit_code  <= trap_code;
            exit_pc    <= trap_pc;
            drain_cnt  <= '0;
            state      <= DRAIN;
            trap_ready <= 1'b0;
            stall      <= 1'b1;
          end
        end
        DRAIN: begin
          if (drain_end) begin
            state     <= DONE;
            halted    <= 1'b1;
            drain_tmo <= wb_pending;
            good_trap <= code_zero && !wb_pending;
            bad_trap  <= !code_zero || wb_pending;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        default: ;  // DONE is absorbing until reset
      endcase
    end
  end

endmodule

// File: tb/tb_trap_halt_ctrl.sv
// Scoreboard bench for trap_halt_ctrl: the driver queues the expected halt record
// for each trap, and a monitor compares it when halted rises.
module tb_trap_halt_ctrl;

  localparam int XLEN      = 64;
  localparam int DRAIN_MAX = 16;
  localparam int CNT_W     = 64;

  logic             clock = 1'b0;
  logic             reset;
  logic             trap_valid;
  logic [XLEN-1:0]  trap_code;
  logic [XLEN-1:0]  trap_pc;
  logic             trap_ready;
  logic             inst_retire;
  logic             wb_pending;
  logic             stall;
  logic             halted;
  logic             good_trap;
  logic             bad_trap;
  logic             drain_tmo;
  logic [XLEN-1:0]  exit_code;
  logic [XLEN-1:0]  exit_pc;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret;

  trap_halt_ctrl #(.XLEN(XLEN), .DRAIN_MAX(DRAIN_MAX), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .trap_valid(trap_valid), .trap_code(trap_code),
    .trap_pc(trap_pc), .trap_ready(trap_ready), .inst_retire(inst_retire),
    .wb_pending(wb_pending), .stall(stall), .halted(halted), .good_trap(good_trap),
    .bad_trap(bad_trap), .drain_tmo(drain_tmo), .exit_code(exit_code),
    .exit_pc(exit_pc), .cycle_cnt(cycle_cnt), .instret(instret)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [XLEN-1:0]  code;
    logic [XLEN-1:0]  pc;
    logic             good;
    logic             bad;
    logic             tmo;
    logic [CNT_W-1:0] inst;
    logic [CNT_W-1:0] cyc;
    int               lat;
    int               accept_edge;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   edge_no = 0;
  int   n_edges;
  logic halted_q = 1'b0;

  always @(posedge clock) edge_no++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %0s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Returns at the falling edge right after the next rising edge.
  task automatic step();
    @(negedge clock);
  endtask

  task automatic wait_halt(input int budget);
    int k = 0;
    while (!halted && k < budget) begin
      step();
      k++;
    end
    if (!halted) check("halt_timeout", 64'(halted), 64'd1);
  endtask

  // Queue the expected halt record for a trap that will be accepted at the next edge.
  task automatic expect_trap(input logic [XLEN-1:0] code, input logic [XLEN-1:0] pc,
                             input logic good, input logic bad, input logic tmo,
                             input logic [CNT_W-1:0] inst, input int lat);
    exp_t e;
    e.code = code; e.pc = pc; e.good = good; e.bad = bad; e.tmo = tmo;
    e.inst = inst; e.lat = lat;
    e.cyc = CNT_W'(n_edges + lat + 1);
    e.accept_edge = edge_no + 1;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    trap_valid = 1'b0;
    inst_retire = 1'b0;
    wb_pending = 1'b0;
    step();
    reset = 1'b1;
    n_edges = 0;
  endtask

  // Monitor: compares the oldest expected record whenever the DUT reports halt.
  always @(negedge clock) begin
    if (halted && !halted_q) begin
      if (sb.size() == 0) begin
        check("unexpected_halt", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("halt_latency", 64'(edge_no - mon_e.accept_edge), 64'(mon_e.lat));
        check("exit_code", exit_code, mon_e.code);
        check("exit_pc", exit_pc, mon_e.pc);
        check("good_trap", 64'(good_trap), 64'(mon_e.good));
        check("bad_trap", 64'(bad_trap), 64'(mon_e.bad));
        check("drain_tmo", 64'(drain_tmo), 64'(mon_e.tmo));
        check("instret_at_halt", instret, mon_e.inst);
        check("cycle_cnt_at_halt", cycle_cnt, mon_e.cyc);
        check("stall_done", 64'(stall), 64'd1);
        check("trap_ready_done", 64'(trap_ready), 64'd0);
      end
    end
    halted_q = halted;
  end

  initial begin
    reset = 1'b0;
    trap_valid = 1'b0;
    trap_code = '0;
    trap_pc = '0;
    inst_retire = 1'b0;
    wb_pending = 1'b0;
    n_edges = 0;

    // 1: reset for 3 cycles, then 10 idle cycles
    repeat (3) step();
    check("rst_trap_ready", 64'(trap_ready), 64'd1);
    check("rst_status", {58'd0, stall, halted, good_trap, bad_trap, drain_tmo, 1'b0}, 64'd0);
    check("rst_exit_code", exit_code, 64'd0);
    check("rst_exit_pc", exit_pc, 64'd0);
    check("rst_cycle_cnt", cycle_cnt, 64'd0);
    check("rst_instret", instret, 64'd0);
    reset = 1'b1;
    n_edges = 0;
    repeat (10) begin step(); n_edges++; end
    check("idle_cycle_cnt", cycle_cnt, 64'd10);
    check("idle_instret", instret, 64'd0);
    check("idle_trap_ready", 64'(trap_ready), 64'd1);

    // 2: five retires, then ebreak (retiring in the same cycle), code 0, no pending
    inst_retire = 1'b1;
    repeat (5) begin step(); n_edges++; end
    trap_valid = 1'b1;
    trap_code = 64'd0;
    trap_pc = 64'h8000_0010;
    expect_trap(64'd0, 64'h8000_0010, 1'b1, 1'b0, 1'b0, 64'd6, 1);
    step();
    trap_valid = 1'b0;
    inst_retire = 1'b0;
    check("drain_stall", 64'(stall), 64'd1);
    check("drain_trap_ready", 64'(trap_ready), 64'd0);
    check("drain_not_halted", 64'(halted), 64'd0);
    wait_halt(40);

    // 3: code 1, writebacks pending for 3 drain cycles
    do_reset();
    trap_valid = 1'b1;
    trap_code = 64'd1;
    trap_pc = 64'h8000_0100;
    wb_pending = 1'b1;
    expect_trap(64'd1, 64'h8000_0100, 1'b0, 1'b1, 1'b0, 64'd0, 4);
    step();
    trap_valid = 1'b0;
    repeat (3) step();
    check("pending_not_halted", 64'(halted), 64'd0);
    wb_pending = 1'b0;
    wait_halt(40);

    // 4+5: code 0, pending stuck -> timeout; re-trap attempts in DRAIN and DONE
    do_reset();
    trap_valid = 1'b1;
    trap_code = 64'd0;
    trap_pc = 64'h8000_0200;
    wb_pending = 1'b1;
    expect_trap(64'd0, 64'h8000_0200, 1'b0, 1'b1, 1'b1, 64'd0, DRAIN_MAX);
    step();
    trap_code = 64'd7;
    trap_pc = 64'h8000_0bad;
    inst_retire = 1'b1;
    wait_halt(40);
    repeat (20) step();
    check("done_cycle_cnt_frozen", cycle_cnt, 64'(DRAIN_MAX + 1));
    check("done_instret_frozen", instret, 64'd0);
    check("done_exit_code_held", exit_code, 64'd0);
    check("done_exit_pc_held", exit_pc, 64'h8000_0200);
    check("done_halted_sticky", 64'(halted), 64'd1);
    check("done_bad_trap", 64'(bad_trap), 64'd1);
    trap_valid = 1'b0;
    inst_retire = 1'b0;

    // 6: reset in the middle of DRAIN, then a clean trap
    do_reset();
    trap_valid = 1'b1;
    trap_code = 64'd3;
    trap_pc = 64'h8000_0300;
    wb_pending = 1'b1;
    step();
    trap_valid = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    step();
    check("midrst_trap_ready", 64'(trap_ready), 64'd1);
    check("midrst_stall", 64'(stall), 64'd0);
    check("midrst_halted", 64'(halted), 64'd0);
    check("midrst_cycle_cnt", cycle_cnt, 64'd0);
    check("midrst_exit_code", exit_code, 64'd0);
    reset = 1'b1;
    wb_pending = 1'b0;
    n_edges = 0;
    inst_retire = 1'b1;
    repeat (2) begin step(); n_edges++; end
    trap_valid = 1'b1;
    trap_code = 64'd0;
    trap_pc = 64'h8000_0400;
    expect_trap(64'd0, 64'h8000_0400, 1'b1, 1'b0, 1'b0, 64'd3, 1);
    step();
    trap_valid = 1'b0;
    inst_retire = 1'b0;
    wait_halt(40);
    step();

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
